// File: rtl/bcd_timekeeper_multi.sv
// rtl/bcd_timekeeper_multi.sv - BCD hh:mm:ss timekeeper with N alarms, 12/24 h view and timed ring
// Optional hourly chime output guarded by macro HOURLY_CHIME_EN.
module bcd_timekeeper_multi #(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = 2,
  parameter int RING_SEC   = 30
) (
  input  logic                  CP,
  input  logic                  CR,
  input  logic                  tick,
  input  logic                  AdjHr,
  input  logic                  AdjMin,
  input  logic                  mode_12h,
  input  logic                  alm_we,
  input  logic [IDX_W-1:0]      alm_idx,
  input  logic [7:0]            alm_hr,
  input  logic [7:0]            alm_min,
  input  logic                  alm_on,
  input  logic                  alm_stop,
  output logic [7:0]            Hour,
  output logic [7:0]            Minute,
  output logic [7:0]            Second,
  output logic [7:0]            Hour_disp,
  output logic                  pm,
  output logic                  ring,
  output logic [NUM_ALARMS-1:0] alm_hit
`ifdef HOURLY_CHIME_EN
  ,
  output logic                  chime
`endif
);

  logic [7:0]            slot_hr  [NUM_ALARMS];
  logic [7:0]            slot_min [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] slot_on;
  logic [7:0]            ring_cnt;
  logic [7:0]            hr_nx, min_nx, sec_nx;
  logic                  normal_wrap;
  logic                  adjust;
  logic [NUM_ALARMS-1:0] match;

  assign adjust = AdjHr | AdjMin;

  // Valid-BCD increment that wraps to 00 after reaching last.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    hr_nx       = Hour;
    min_nx      = Minute;
    sec_nx      = Second;
    normal_wrap = 1'b0;
    if (tick) begin
      if (adjust) begin
        if (AdjHr)  hr_nx  = bcd_inc(Hour, 8'h23);
        if (AdjMin) min_nx = bcd_inc(Minute, 8'h59);
      end else begin
        sec_nx = bcd_inc(Second, 8'h59);
        if (Second == 8'h59) begin
          normal_wrap = 1'b1;
          min_nx      = bcd_inc(Minute, 8'h59);
          if (Minute == 8'h59) hr_nx = bcd_inc(Hour, 8'h23);
        end
      end
    end
  end

  // Slots holding out-of-range values can never equal a valid time, so no range check here.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ALARMS; i++)
      match[i] = normal_wrap && slot_on[i] && (slot_hr[i] == hr_nx) && (slot_min[i] == min_nx);
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      Hour     <= 8'h00;
      Minute   <= 8'h00;
      Second   <= 8'h00;
      ring     <= 1'b0;
      alm_hit  <= '0;
      ring_cnt <= 8'd0;
      slot_on  <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_hr[i]  <= 8'h00;
        slot_min[i] <= 8'h00;
      end
    end else begin
      Hour   <= hr_nx;
      Minute <= min_nx;
      Second <= sec_nx;

      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (alm_we && (alm_idx == IDX_W'(i))) begin
          slot_hr[i]  <= alm_hr;
          slot_min[i] <= alm_min;
          slot_on[i]  <= alm_on;
        end
      end

      // Stop beats a coincident match; a match while ringing reloads and accumulates.
      if (alm_stop) begin
        ring     <= 1'b0;
        alm_hit  <= '0;
        ring_cnt <= 8'd0;
      end else if (|match) begin
        ring     <= 1'b1;
        alm_hit  <= alm_hit | match;
        ring_cnt <= 8'(RING_SEC);
      end else if (tick && ring) begin
        if (ring_cnt <= 8'd1) begin
          ring     <= 1'b0;
          alm_hit  <= '0;
          ring_cnt <= 8'd0;
        end else begin
          ring_cnt <= ring_cnt - 8'd1;
        end
      end
    end
  end

  always_comb begin
    pm        = (Hour >= 8'h12);
    Hour_disp = Hour;
    if (mode_12h) begin
      if (Hour == 8'h00)
        Hour_disp = 8'h12;
      else if (Hour >= 8'h22)
        Hour_disp = {4'd1, Hour[3:0] - 4'd2};
      else if (Hour >= 8'h20)
        Hour_disp = {4'd0, Hour[3:0] + 4'd8};
      else if (Hour >= 8'h13)
        Hour_disp = {4'd0, Hour[3:0] - 4'd2};
    end
  end

`ifdef HOURLY_CHIME_EN
  logic chime_q;

  // Latched per second from the time being entered; only normal counting can raise it.
  always_ff @(posedge CP) begin
    if (CR)
      chime_q <= 1'b0;
    else if (tick)
      chime_q <= !adjust && (((min_nx == 8'h59) && (sec_nx >= 8'h55)) ||
                             ((min_nx == 8'h00) && (sec_nx == 8'h00)));
  end

  assign chime = chime_q & ~adjust;
`endif

endmodule

// File: tb/tb_bcd_timekeeper_multi.sv
// tb/tb_bcd_timekeeper_multi.sv - scoreboard bench for bcd_timekeeper_multi against a seconds-of-day model
// Checks the chime output too when HOURLY_CHIME_EN is defined.
module tb_bcd_timekeeper_multi;

  localparam int NA   = 4;
  localparam int IW   = 3;
  localparam int RING = 3;

  logic          clk = 1'b0;
  logic          cr = 1'b0, tick = 1'b0, adj_hr = 1'b0, adj_min = 1'b0, mode = 1'b0;
  logic          we = 1'b0, on = 1'b0, stop = 1'b0;
  logic [IW-1:0] idx = '0;
  logic [7:0]    ahr = 8'h00, amin = 8'h00;
  logic [7:0]    hour, minute, second, hour_disp;
  logic          pm, ring;
  logic [NA-1:0] hit;
`ifdef HOURLY_CHIME_EN
  logic          chime;
`endif

  bcd_timekeeper_multi #(.NUM_ALARMS(NA), .IDX_W(IW), .RING_SEC(RING)) dut (
    .CP(clk), .CR(cr), .tick(tick), .AdjHr(adj_hr), .AdjMin(adj_min), .mode_12h(mode),
    .alm_we(we), .alm_idx(idx), .alm_hr(ahr), .alm_min(amin), .alm_on(on), .alm_stop(stop),
    .Hour(hour), .Minute(minute), .Second(second), .Hour_disp(hour_disp), .pm(pm),
    .ring(ring), .alm_hit(hit)
`ifdef HOURLY_CHIME_EN
    , .chime(chime)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    h, m, s, hd;
    logic          pm, ring, ch;
    logic [NA-1:0] hit;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: time kept as seconds since midnight.
  int            t = 0;
  logic [7:0]    m_hr [NA];
  logic [7:0]    m_min[NA];
  bit   [NA-1:0] m_on  = '0;
  bit            m_ring = 0;
  int            m_rem = 0;
  bit   [NA-1:0] m_hit = '0;
  bit            m_ch = 0;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, expv, $time);
    end
  endtask

  task automatic step(input bit c, input bit tk, input bit ah, input bit am, input bit w,
                      input int ix, input logic [7:0] hr, input logic [7:0] mn,
                      input bit o, input bit sp);
    int h, m, s, hd;
    bit normal;
    bit [NA-1:0] mv;
    exp_t e;
    cr = c; tick = tk; adj_hr = ah; adj_min = am; we = w; idx = IW'(ix);
    ahr = hr; amin = mn; on = o; stop = sp;
    if (c) begin
      t = 0; m_on = '0; m_ring = 0; m_rem = 0; m_hit = '0; m_ch = 0;
      for (int i = 0; i < NA; i++) begin m_hr[i] = 8'h00; m_min[i] = 8'h00; end
    end else begin
      h = t / 3600; m = (t / 60) % 60; s = t % 60;
      normal = 0; mv = '0;
      if (tk) begin
        if (ah || am) begin
          h = (h + int'(ah)) % 24;
          m = (m + int'(am)) % 60;
          m_ch = 0;
        end else begin
          t = (t + 1) % 86400;
          h = t / 3600; m = (t / 60) % 60; s = t % 60;
          normal = 1;
          m_ch = (m == 59 && s >= 55) || (m == 0 && s == 0);
        end
      end
      if (normal && s == 0)
        for (int i = 0; i < NA; i++)
          mv[i] = m_on[i] && m_hr[i] == bcd(h) && m_min[i] == bcd(m);
      if (w && ix < NA) begin m_hr[ix] = hr; m_min[ix] = mn; m_on[ix] = o; end
      if (sp) begin
        m_ring = 0; m_hit = '0; m_rem = 0;
      end else if (mv != 0) begin
        m_ring = 1; m_hit = m_hit | mv; m_rem = RING;
      end else if (tk && m_ring) begin
        m_rem--;
        if (m_rem == 0) begin m_ring = 0; m_hit = '0; end
      end
      t = h * 3600 + m * 60 + s;
    end
    h = t / 3600;
    hd = mode ? ((h % 12 == 0) ? 12 : h % 12) : h;
    e.h = bcd(h); e.m = bcd((t / 60) % 60); e.s = bcd(t % 60); e.hd = bcd(hd);
    e.pm = (h >= 12); e.ring = m_ring; e.hit = m_hit; e.ch = m_ch && !(ah || am);
    @(posedge clk);
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
  endtask

  task automatic ticks(input int n, input bit ah, input bit am, input bit sp);
    for (int i = 0; i < n; i++) step(0, 1, ah, am, 0, 0, 8'h00, 8'h00, 0, sp);
  endtask

  task automatic wr(input int ix, input logic [7:0] hr, input logic [7:0] mn, input bit o);
    step(0, 0, 0, 0, 1, ix, hr, mn, o, 0);
  endtask

  // Seconds by normal counting first, then minutes and hours by adjust; ends by stopping any ring.
  task automatic set_time(input int h, input int m, input int s);
    ticks((s - t % 60 + 60) % 60, 0, 0, 0);
    ticks((m - (t / 60) % 60 + 60) % 60, 0, 1, 0);
    ticks((h - t / 3600 + 24) % 24, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("hour", hour, e.h);
        chk("minute", minute, e.m);
        chk("second", second, e.s);
        chk("hour_disp", hour_disp, e.hd);
        chk("pm", {7'd0, pm}, {7'd0, e.pm});
        chk("ring", {7'd0, ring}, {7'd0, e.ring});
        chk("alm_hit", 8'(hit), 8'(e.hit));
`ifdef HOURLY_CHIME_EN
        chk("chime", {7'd0, chime}, {7'd0, e.ch});
`endif
      end
    end
  end

  initial begin
    int r, cm;
    mode = 1'b1;
    do_reset();
    set_time(23, 59, 50);
    ticks(10, 0, 0, 0);

    mode = 1'b0;
    set_time(10, 59, 30);
    ticks(3, 0, 1, 0);
    set_time(23, 15, 0);
    ticks(1, 1, 0, 0);

    wr(2, 8'h07, 8'h30, 1);
    set_time(7, 29, 58);
    ticks(2, 0, 0, 0);
    ticks(3, 0, 0, 0);

    do_reset();
    wr(0, 8'h08, 8'h00, 1);
    wr(1, 8'h08, 8'h00, 1);
    set_time(7, 59, 59);
    ticks(1, 0, 0, 1);
    set_time(7, 59, 59);
    ticks(2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
    ticks(1, 0, 0, 0);

    wr(5, 8'h06, 8'h00, 1);
    wr(3, 8'h06, 8'h00, 0);
    wr(0, 8'h0A, 8'h00, 1);
    set_time(5, 59, 59);
    ticks(1, 0, 0, 0);
    wr(3, 8'h06, 8'h00, 1);
    set_time(5, 0, 0);
    ticks(1, 1, 0, 0);

    mode = 1'b1;
    set_time(12, 59, 54);
    ticks(7, 0, 0, 0);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 999);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if (r < 5) begin
        do_reset();
      end else if (r < 120) begin
        cm = ((t / 60) + 1) % 60;
        step(0, $urandom_range(0, 1), 0, 0, 1, $urandom_range(0, 7),
             ($urandom_range(0, 3) == 0) ? 8'($urandom) : bcd((t / 3600 + int'(cm == 0)) % 24),
             ($urandom_range(0, 3) == 0) ? 8'($urandom) : bcd(cm),
             $urandom_range(0, 4) != 0, 0);
      end else begin
        step(0, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
             $urandom_range(0, 14) == 0, 0, 0, 8'h00, 8'h00, 0, $urandom_range(0, 39) == 0);
      end
    end

    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_timekeeper_multi.md
Name: bcd_timekeeper_multi

Overview:
- Parametrised successor to the single-alarm clock core: BCD hh:mm:ss timekeeper driven by a 1 Hz tick strobe, with N programmable alarms.
- Adds a 12/24 h display view and a timed ring output with stop.
- Sits between the frequency divider (which supplies tick) and the seg display/buzzer mixing logic.

Parameters:
- NUM_ALARMS, 4, number of alarm slots (1..16).
- IDX_W, 2, alarm index width; must satisfy 2**IDX_W >= NUM_ALARMS.
- RING_SEC, 30, ring duration in ticks (1..255).

Ports:
- CP  input  1  system clock; all logic on posedge CP.
- CR  input  1  synchronous active-high reset.
- tick  input  1  one-CP-cycle 1 Hz strobe, synchronous to CP.
- AdjHr  input  1  level; while high, hour advances once per tick.
- AdjMin  input  1  level; while high, minute advances once per tick.
- mode_12h  input  1  0 = 24 h view, 1 = 12 h view (affects Hour_disp/pm only).
- alm_we  input  1  alarm slot write strobe.
- alm_idx  input  IDX_W  slot written.
- alm_hr  input  8  BCD hour 00..23.
- alm_min  input  8  BCD minute 00..59.
- alm_on  input  1  slot enable.
- alm_stop  input  1  stop an active ring.
- Hour  output  8  BCD 24 h hour.
- Minute  output  8  BCD minute.
- Second  output  8  BCD second.
- Hour_disp  output  8  BCD hour per mode_12h.
- pm  output  1  1 when Hour >= 12.
- ring  output  1  alarm ring active.
- alm_hit  output  NUM_ALARMS  one-hot-or-more, the slots that fired; held while ring is high.

Behaviour:
- Reset (CR=1 at posedge CP):
  - Hour=Minute=Second=00, ring=0, alm_hit=0, ring counter=0.
  - All alarm slots cleared to 00:00, disabled.
  - Hour_disp=12 if mode_12h else 00; pm=0.
  - Reset mid-ring aborts the ring the same edge.
- Counting: all digits are pure BCD, each nibble 0..9; never produce A..F.
- Normal count, on tick with AdjHr=AdjMin=0:
  - Second +1; 59 wraps to 00 with carry to Minute.
  - Minute 59 wraps to 00 with carry to Hour.
  - Hour 23 wraps to 00.
  - Update visible the cycle after the tick edge (1-cycle latency).
- Adjust, on tick with AdjHr or AdjMin high:
  - AdjHr: Hour +1 mod 24.
  - AdjMin: Minute +1 mod 60, no carry into Hour.
  - Both high: both advance in the same tick.
  - Second is held, not counted, while either adjust is high.
- No tick: time registers hold.
- Alarm write: on alm_we, the slot at alm_idx loads {alm_hr, alm_min, alm_on} next edge.
  - alm_idx >= NUM_ALARMS: write ignored.
  - Non-BCD or out-of-range values (hr > 23 or min > 59): stored as given and can never match.
- Alarm match, evaluated only on a normal-count tick that wraps Second 59 -> 00:
  - Compare the new Hour:Minute against each enabled slot.
  - Any match: ring=1, alm_hit = match vector, ring counter = RING_SEC; visible the edge after the tick.
  - Adjust ticks never fire alarms.
- Ring:
  - Each subsequent tick while ring=1 decrements the counter.
  - Counter reaching 0 clears ring and alm_hit.
  - alm_stop while ring=1 clears ring, alm_hit and counter next edge.
  - Simultaneous alm_stop and new match in the same cycle: stop wins, no ring.
  - New match while already ringing: counter reloads to RING_SEC and alm_hit is ORed with the new matches.
- Display view (combinational from Hour):
  - mode_12h=0: Hour_disp=Hour.
  - mode_12h=1: 00 -> 12; 01..12 -> unchanged; 13..23 -> Hour-12 (BCD correct, e.g. 20 -> 08).
  - pm = (Hour >= 12) in both modes.

Optional Feature:
- Macro HOURLY_CHIME_EN.
- Defined:
  - Adds output chime (1 bit, reset 0).
  - chime=1 for the whole second while Minute=59 and Second in {55,56,57,58,59}, and also during Second=00 of the new hour; otherwise 0.
  - Suppressed while AdjHr or AdjMin is high.
- Undefined: no chime port, no related logic.

Test Plan:
- Rollover: CR pulse; preload via AdjHr/AdjMin to 23:59:50; 10 ticks -> 00:00:00; Hour_disp=12 with mode_12h=1; pm=0.
- Adjust: AdjMin=1 at 10:59:30 for 3 ticks -> 10:02:30 (no hour carry, Second held). AdjHr=1 at 23:xx for 1 tick -> 00.
- Alarm fire: slot 2 = 07:30 on, time 07:29:58; 2 ticks -> ring=1, alm_hit=4'b0100. RING_SEC=3: ring clears after the 3rd further tick.
- Stop priority: two slots at 08:00, alm_stop asserted the same cycle as the match tick -> ring stays 0. Repeat without stop: alm_hit=both bits set; alm_stop mid-ring clears the next edge.
- Guards: alm_idx=5 with NUM_ALARMS=4 -> no slot changes. Slot 06:00 disabled -> no ring. Adjusting through 06:00 with slot enabled -> no ring.
- With HOURLY_CHIME_EN: 12:59:54 -> chime 0; chime 1 across 12:59:55 through 13:00:00; chime 0 at 13:00:01. 12 h view at 13:00 -> Hour_disp=01, pm=1.
